// File: rtl/boss_pkg.sv
// Shared constants, state and phase encodings for the boss hit-point tracker.
// Optional regeneration is enabled by defining BOSS_HEAL_EN.
package boss_pkg;

    localparam int HP_W  = 10;
    localparam int CNT_W = 6;

    localparam int BOSS_HP_MAX    = 450;
    localparam int BOSS_THR_HIGH  = 300;
    localparam int BOSS_THR_LOW   = 150;
    localparam int BOSS_DMG       = 10;
    localparam int BOSS_BOX_W     = 64;
    localparam int BOSS_BOX_H     = 48;
    localparam int BOSS_INV_HIT   = 8;
    localparam int BOSS_INV_PHASE = 32;

    localparam int HEAL_QUIET  = 64;
    localparam int HEAL_PERIOD = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_HIGH = 2'd0,
        PH_MID  = 2'd1,
        PH_LOW  = 2'd2,
        PH_DEAD = 2'd3
    } phase_t;

    function automatic phase_t hp_phase(input logic [HP_W-1:0] hp);
        phase_t ph;
        if (hp == '0)
            ph = PH_DEAD;
        else if (hp > HP_W'(BOSS_THR_HIGH))
            ph = PH_HIGH;
        else if (hp > HP_W'(BOSS_THR_LOW))
            ph = PH_MID;
        else
            ph = PH_LOW;
        return ph;
    endfunction

endpackage

// File: rtl/boss_hitbox.sv
// Combinational bullet-versus-box overlap test; right/bottom edges use 11-bit sums
// so a box near the screen edge never wraps around.
module boss_hitbox
    import boss_pkg::*;
#(
    parameter int BOX_W = BOSS_BOX_W,
    parameter int BOX_H = BOSS_BOX_H
) (
    input  logic        valid,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic [9:0]  bx,
    input  logic [9:0]  by,
    output logic        hit
);

    logic [10:0] right;
    logic [10:0] bottom;
    logic        in_x;
    logic        in_y;

    assign right  = {1'b0, bx} + 11'(BOX_W);
    assign bottom = {1'b0, by} + 11'(BOX_H);

    assign in_x = ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < right);
    assign in_y = ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < bottom);

    assign hit = valid && in_x && in_y;

endmodule

// File: rtl/boss_health.sv
// Boss hit-point tracker: registers hits, runs invulnerability windows, flags defeat.
// Defining BOSS_HEAL_EN adds slow regeneration while the boss sits in phase 2.
module boss_health
    import boss_pkg::*;
#(
    parameter int HP_MAX    = BOSS_HP_MAX,
    parameter int DMG       = BOSS_DMG,
    parameter int BOX_W     = BOSS_BOX_W,
    parameter int BOX_H     = BOSS_BOX_H,
    parameter int INV_HIT   = BOSS_INV_HIT,
    parameter int INV_PHASE = BOSS_INV_PHASE
) (
    input  logic        clk22,
    input  logic        rst,
    input  logic        gamestart,
    input  logic        boss,
    input  logic [9:0]  bossx,
    input  logic [9:0]  bossy,
    input  logic        bulvalid,
    input  logic [9:0]  bulx,
    input  logic [9:0]  buly,
    output logic [9:0]  bosshp,
    output logic [1:0]  phase,
    output logic        hit_ack,
    output logic        invuln,
    output logic        bossdead
);

    state_t              state;
    state_t              state_nx;
    logic [HP_W-1:0]     hp_nx;
    logic [HP_W-1:0]     hit_hp;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                ack_nx;
    logic                dead_nx;
    logic                overlap;
    logic                crossed;
    logic                restart;

    assign restart = rst || gamestart;

    boss_hitbox #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_hitbox (
        .valid (bulvalid),
        .px    (bulx),
        .py    (buly),
        .bx    (bossx),
        .by    (bossy),
        .hit   (overlap)
    );

    assign hit_hp  = (bosshp <= HP_W'(DMG)) ? '0 : bosshp - HP_W'(DMG);
    assign crossed = ((bosshp > HP_W'(BOSS_THR_HIGH)) && (hit_hp <= HP_W'(BOSS_THR_HIGH))) ||
                     ((bosshp > HP_W'(BOSS_THR_LOW))  && (hit_hp <= HP_W'(BOSS_THR_LOW)));

`ifdef BOSS_HEAL_EN
    logic [6:0] quiet_cnt;
    logic [3:0] heal_cnt;
    logic       quiet_ok;
    logic       heal_due;

    assign quiet_ok = (state == ST_ACTIVE) && boss && !overlap && (hp_phase(bosshp) == PH_LOW);
    assign heal_due = quiet_ok && (quiet_cnt == 7'(HEAL_QUIET)) && (heal_cnt == 4'(HEAL_PERIOD - 1));

    // Quiet-time counter saturates at 64, then the period counter paces each +1 HP.
    always_ff @(posedge clk22) begin
        if (restart || !quiet_ok) begin
            quiet_cnt <= '0;
            heal_cnt  <= '0;
        end else if (quiet_cnt < 7'(HEAL_QUIET)) begin
            quiet_cnt <= quiet_cnt + 7'd1;
        end else begin
            heal_cnt <= heal_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        hp_nx    = bosshp;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        dead_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (boss)
                    state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!boss) begin
                    state_nx = ST_IDLE;
                end else if (overlap) begin
                    ack_nx = 1'b1;
                    hp_nx  = hit_hp;
                    if (hit_hp == '0) begin
                        state_nx = ST_DEAD;
                        dead_nx  = 1'b1;
                    end else if (crossed) begin
                        state_nx = ST_INVULN;
                        cnt_nx   = CNT_W'(INV_PHASE - 1);
                    end else begin
                        state_nx = ST_INVULN;
                        cnt_nx   = CNT_W'(INV_HIT - 1);
                    end
                end else begin
`ifdef BOSS_HEAL_EN
                    if (heal_due && (bosshp < HP_W'(BOSS_THR_LOW)))
                        hp_nx = bosshp + HP_W'(1);
`endif
                end
            end
            ST_INVULN: begin
                if (!boss) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    ack_nx = overlap;
                    if (cnt == '0)
                        state_nx = ST_ACTIVE;
                    else
                        cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_DEAD: begin
                hp_nx = '0;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Phase and invuln follow the next-state values so they line up with bosshp.
    always_ff @(posedge clk22) begin
        if (restart) begin
            state    <= ST_IDLE;
            bosshp   <= HP_W'(HP_MAX);
            cnt      <= '0;
            phase    <= hp_phase(HP_W'(HP_MAX));
            hit_ack  <= 1'b0;
            invuln   <= 1'b0;
            bossdead <= 1'b0;
        end else begin
            state    <= state_nx;
            bosshp   <= hp_nx;
            cnt      <= cnt_nx;
            phase    <= (state_nx == ST_DEAD) ? PH_DEAD : hp_phase(hp_nx);
            hit_ack  <= ack_nx;
            invuln   <= (state_nx == ST_INVULN);
            bossdead <= dead_nx;
        end
    end

endmodule

// File: tb/tb_boss_health.sv
// Directed bench for boss_health: hits, invulnerability windows, phases, geometry, defeat.
// With BOSS_HEAL_EN defined the regeneration expectation changes to 150.
module tb_boss_health;

    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       gamestart = 1'b0;
    logic       boss = 1'b0;
    logic [9:0] bossx = 10'd100;
    logic [9:0] bossy = 10'd75;
    logic       bulvalid = 1'b0;
    logic [9:0] bulx = 10'd0;
    logic [9:0] buly = 10'd0;
    logic [9:0] bosshp;
    logic [1:0] phase;
    logic       hit_ack;
    logic       invuln;
    logic       bossdead;

    int checks = 0;
    int failures = 0;
    int n;

    boss_health dut (
        .clk22     (clk22),
        .rst       (rst),
        .gamestart (gamestart),
        .boss      (boss),
        .bossx     (bossx),
        .bossy     (bossy),
        .bulvalid  (bulvalid),
        .bulx      (bulx),
        .buly      (buly),
        .bosshp    (bosshp),
        .phase     (phase),
        .hit_ack   (hit_ack),
        .invuln    (invuln),
        .bossdead  (bossdead)
    );

    always #5 clk22 = ~clk22;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    // Counts the cycles invuln stays high, bounded so a stuck window cannot hang the run.
    task automatic waitInvuln(output int cycles);
        cycles = 0;
        while (invuln && cycles < 100) begin
            tick();
            cycles++;
        end
        if (cycles >= 100)
            checkOutput("invuln_timeout", int'(invuln), 0);
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
        bulx     = x;
        buly     = y;
        bulvalid = 1'b1;
        tick();
        bulvalid = 1'b0;
    endtask

    task automatic hitAndWait();
        int c;
        applyStimulus(bossx + 10'd20, bossy + 10'd15);
        waitInvuln(c);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_hp", bosshp, 450);
        checkOutput("reset_phase", phase, 0);
        checkOutput("reset_ack", hit_ack, 0);
        checkOutput("reset_invuln", invuln, 0);
        checkOutput("reset_dead", bossdead, 0);

        // First hit at (120,90) against box at (100,75)
        boss = 1'b1;
        tick();
        checkOutput("idle_no_change", bosshp, 450);
        applyStimulus(10'd120, 10'd90);
        checkOutput("hit1_hp", bosshp, 440);
        checkOutput("hit1_ack", hit_ack, 1);
        checkOutput("hit1_invuln", invuln, 1);
        checkOutput("hit1_phase", phase, 0);
        waitInvuln(n);
        checkOutput("inv_hit_len", n, 8);
        checkOutput("ack_cleared", hit_ack, 0);

        // Bullet held over the box for 20 cycles from full health
        gamestart = 1'b1;
        tick();
        gamestart = 1'b0;
        checkOutput("restart_hp", bosshp, 450);
        tick();
        bulx = 10'd120;
        buly = 10'd90;
        bulvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput($sformatf("held_hp_%0d", k), bosshp, 450 - 10 * (k / 9 + 1));
            checkOutput($sformatf("held_ack_%0d", k), hit_ack, 1);
        end
        bulvalid = 1'b0;
        waitInvuln(n);

        // Edge geometry
        applyStimulus(10'd163, 10'd90);
        checkOutput("edge_x63_ack", hit_ack, 1);
        checkOutput("edge_x63_hp", bosshp, 410);
        waitInvuln(n);
        applyStimulus(10'd164, 10'd90);
        checkOutput("edge_x64_ack", hit_ack, 0);
        checkOutput("edge_x64_hp", bosshp, 410);
        applyStimulus(10'd120, 10'd123);
        checkOutput("edge_y48_ack", hit_ack, 0);
        applyStimulus(10'd120, 10'd74);
        checkOutput("edge_yabove_ack", hit_ack, 0);
        bossx = 10'd1000;
        applyStimulus(10'd1020, 10'd90);
        checkOutput("nowrap_ack", hit_ack, 1);
        checkOutput("nowrap_hp", bosshp, 400);
        waitInvuln(n);

        // Boss leaving in the same cycle as an overlap
        boss = 1'b0;
        applyStimulus(10'd1020, 10'd90);
        checkOutput("leave_ack", hit_ack, 0);
        checkOutput("leave_hp", bosshp, 400);
        boss = 1'b1;
        tick();

        // Phase thresholds
        for (int i = 0; i < 50 && bosshp > 10'd310; i++)
            hitAndWait();
        checkOutput("pre300_hp", bosshp, 310);
        checkOutput("pre300_phase", phase, 0);
        applyStimulus(bossx + 10'd5, bossy + 10'd5);
        checkOutput("cross300_hp", bosshp, 300);
        checkOutput("cross300_phase", phase, 1);
        waitInvuln(n);
        checkOutput("inv_phase1_len", n, 32);
        for (int i = 0; i < 50 && bosshp > 10'd160; i++)
            hitAndWait();
        applyStimulus(bossx + 10'd5, bossy + 10'd5);
        checkOutput("cross150_hp", bosshp, 150);
        checkOutput("cross150_phase", phase, 2);
        waitInvuln(n);
        checkOutput("inv_phase2_len", n, 32);

        // Regeneration window in phase 2
        applyStimulus(bossx + 10'd5, bossy + 10'd5);
        checkOutput("hp140", bosshp, 140);
        waitInvuln(n);
        checkOutput("inv_hit_len2", n, 8);
        repeat (300) tick();
`ifdef BOSS_HEAL_EN
        checkOutput("heal_hp", bosshp, 150);
`else
        checkOutput("heal_hp", bosshp, 140);
`endif
        checkOutput("heal_phase", phase, 2);

        // Killing blow and dead state
        for (int i = 0; i < 50 && bosshp > 10'd10; i++)
            hitAndWait();
        checkOutput("prekill_hp", bosshp, 10);
        bulx = bossx + 10'd5;
        buly = bossy + 10'd5;
        bulvalid = 1'b1;
        tick();
        checkOutput("kill_hp", bosshp, 0);
        checkOutput("kill_phase", phase, 3);
        checkOutput("kill_dead", bossdead, 1);
        checkOutput("kill_ack", hit_ack, 1);
        checkOutput("kill_invuln", invuln, 0);
        tick();
        checkOutput("dead_ack", hit_ack, 0);
        checkOutput("dead_pulse", bossdead, 0);
        checkOutput("dead_hp", bosshp, 0);
        checkOutput("dead_phase", phase, 3);
        bulvalid = 1'b0;
        gamestart = 1'b1;
        tick();
        gamestart = 1'b0;
        checkOutput("revive_hp", bosshp, 450);
        checkOutput("revive_phase", phase, 0);

        // Restart aborting an invulnerability window
        tick();
        applyStimulus(bossx + 10'd5, bossy + 10'd5);
        checkOutput("abort_pre_invuln", invuln, 1);
        gamestart = 1'b1;
        tick();
        gamestart = 1'b0;
        checkOutput("abort_invuln", invuln, 0);
        checkOutput("abort_hp", bosshp, 450);
        checkOutput("abort_ack", hit_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/boss_health.md
# boss_health

Boss hit-point tracker directly upstream of the boss motion block. Registers bullet hits against the boss hitbox, maintains `bosshp` (the value the motion block uses to pick its movement phase and to decide boss presence), enforces invulnerability windows, and signals defeat. Runs on the game tick clock `clk22`.

## Interface
Parameters:
- HP_MAX, 450, starting hit points (must be ≤450 so the boss appears)
- DMG, 10, HP removed per registered hit
- BOX_W, 64, hitbox width in pixels
- BOX_H, 48, hitbox height in pixels
- INV_HIT, 8, invulnerability cycles after an ordinary hit
- INV_PHASE, 32, invulnerability cycles after a phase-threshold crossing

Ports:
- clk22  in  1  game tick clock
- rst  in  1  reset (synchronous, active-high)
- gamestart  in  1  synchronous restart; same effect as rst
- boss  in  1  boss present (from motion block)
- bossx, bossy  in  10  boss top-left position
- bulvalid  in  1  player bullet live this cycle
- bulx, buly  in  10  bullet position
- bosshp  out  10  current hit points
- phase  out  2  0: hp>300, 1: 151..300, 2: 1..150, 3: hp==0
- hit_ack  out  1  one-cycle pulse: bullet consumed by boss
- invuln  out  1  high while damage is suppressed
- bossdead  out  1  one-cycle pulse when hp reaches 0

## Operation
- Overlap = bulvalid && bulx ≥ bossx && bulx < bossx+BOX_W && buly ≥ bossy && buly < bossy+BOX_H; sums computed at 11 bits, no wrap.
- States: IDLE, ACTIVE, INVULN, DEAD.
- IDLE: overlap ignored, no ack. boss=1 → ACTIVE. hp retained.
- ACTIVE: overlap → hit_ack=1, hp ← (hp ≤ DMG) ? 0 : hp−DMG. New hp 0 → DEAD, bossdead=1. Else if a threshold was crossed (old>300 && new≤300, or old>150 && new≤150) → INVULN for INV_PHASE cycles, else INVULN for INV_HIT cycles. boss=0 → IDLE.
- INVULN: overlap → hit_ack=1, hp unchanged (bullet absorbed). 6-bit counter loaded with N−1 on entry; counter 0 → ACTIVE, so INVULN lasts exactly N cycles. boss=0 → IDLE, counter cleared.
- DEAD: hp held 0, phase 3, no ack; exit only by rst/gamestart.
- boss=0 and overlap in the same cycle in ACTIVE: leave to IDLE, no hit.
- phase and invuln are registered, derived from next-state hp/state.

## Timing
- Reset/gamestart: bosshp=HP_MAX, state IDLE, phase 0, hit_ack 0, invuln 0, bossdead 0, counter 0; gamestart mid-INVULN or in DEAD aborts immediately.
- Inputs sampled at posedge N; bosshp, hit_ack, phase, invuln, bossdead update at posedge N (visible after edge), i.e. one-cycle latency from overlap to new hp.
- At most one hit per cycle; ack is never asserted two consecutive cycles by a damaging hit (INVULN follows).
- bossdead and hit_ack assert in the same cycle for the killing hit.

## Configuration
- BOSS_HEAL_EN defined: in ACTIVE with phase 2, after 64 consecutive cycles without overlap, hp increments by 1 every 16 cycles, capped at 150 (never re-enters phase 1); any overlap resets the idle counter. Not defined: no regeneration logic; hp only decreases.

## Structure
- Package boss_pkg: HP_MAX, thresholds 300/150, DMG, BOX_W, BOX_H, INV_HIT, INV_PHASE, state enum, phase encoding.
- Sub-module boss_hitbox: combinational overlap compare (bullet vs box, 11-bit arithmetic), reusable for enemy hitboxes.

## Test plan
- Reset, boss=1, bossx=100,bossy=75, bullet at (120,90) valid 1 cycle → next edge bosshp=440, hit_ack=1, invuln=1 for 8 cycles.
- Bullet held overlapping for 20 cycles from hp=450 → hits at cycles 0, 9, 18; bosshp 440, 430, 420; acks every cycle.
- hp=310, hit → bosshp=300, phase=1, invuln 32 cycles; hit at hp=160 → 150, phase=2.
- hp=5, hit → bosshp=0, phase=3, bossdead and hit_ack pulse together; further bullets no ack; gamestart → bosshp=450, IDLE.
- Edge geometry: bullet at x=bossx+63 → hit; x=bossx+64 → no hit; bossx=1000 with bulx=1020 → hit, no wrap.
- BOSS_HEAL_EN: hp=140 phase 2, no bullets 64+160 cycles → bosshp=150 and stays; without macro stays 140.
